dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and sequencer for the single-port data SPRAM pair (two 16-bit SPRAM macros forming one 32-bit word). It shares the memory between requester A (CPU data path) and requester B (loader/debug port) using a valid/ready handshake. It drives the SPRAM address, data, nibble write-mask, write-enable and chip-select from registers, and returns read data to the requester that issued the read. The block sits between the data cache state machine and the SPRAM macros.

## Interface
- `ADDR_W`, default 14: SPRAM word-address width.
- `FIXED_PRIO`, default 0: 0 selects round-robin; 1 makes A always win.
- `clk` in 1: single clock; every register is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `a_req` in 1: A request valid; held with its command stable until `a_gnt`.
- `a_we` in 1: A write (1) or read (0).
- `a_addr` in ADDR_W: A word address.
- `a_wdata` in 32: A write data.
- `a_be` in 4: A byte enables (bit i covers byte i).
- `a_gnt` out 1: combinational; request accepted at this edge.
- `a_rvalid` out 1: one-cycle pulse; `a_rdata` valid.
- `a_rdata` out 32: registered read data.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_be`, `b_gnt`, `b_rvalid`, `b_rdata`: same as the A ports, for requester B.
- `mem_addr` out ADDR_W: registered SPRAM address.
- `mem_wdata` out 32: registered; [31:16] to the upper macro, [15:0] to the lower.
- `mem_maskwren` out 8: registered {be3,be3,be2,be2,be1,be1,be0,be0}; [7:4] to the upper macro, [3:0] to the lower.
- `mem_wren` out 1: registered write enable.
- `mem_cs` out 1: registered chip select.
- `mem_rdata` in 32: SPRAM DATAOUT, valid in the cycle after the access cycle.

## Operation
- States:
  - IDLE: no access in flight.
  - ACCESS: `mem_*` driven for one cycle; the SPRAM samples at the edge that ends ACCESS.
  - WAIT: read only; `mem_rdata` valid.
- `ready` is 1 in IDLE, in WAIT, and in ACCESS when the latched op is a write. It is 0 in ACCESS for a read.
- Winner selection:
  - If only one requester asserts req, that requester wins.
  - If both assert req and FIXED_PRIO=1, A wins.
  - If both assert req and FIXED_PRIO=0, the winner is the requester not recorded in `last`.
  - `last` updates on every handshake.
  - `last` resets to B, so A wins the first conflict.
- `x_gnt = ready & x_req & winner==x & rst_n`. A transfer occurs at any edge with `x_req & x_gnt`.
- On a transfer:
  - Latch `mem_addr`, `mem_wdata` and `mem_maskwren` from the winner.
  - `mem_wren` = winner `we`; `mem_cs` = 1.
  - Latch the owner ID and op type; next state = ACCESS.
- ACCESS, write:
  - Next state is ACCESS on a new transfer, else IDLE.
  - No response pulse; the write is complete when `gnt` is seen.
- ACCESS, read: next state = WAIT; `mem_wren` = 0 and `mem_cs` = 0 on exit.
- WAIT:
  - At the WAIT-ending edge, register `mem_rdata` into the owner's `x_rdata` and pulse the owner's `x_rvalid` for one cycle.
  - The same edge may accept a new transfer, giving next state ACCESS; otherwise next state is IDLE.
- `mem_cs` and `mem_wren` are 1 only in ACCESS cycles. `mem_wren` is 1 only for writes.
- The non-owner's `rdata` holds its previous value.
- A write with `be`=0 still performs an ACCESS cycle, with `mem_maskwren`=0.

## Timing
- Reset (asynchronous, while `rst_n`=0):
  - State IDLE, `last`=B.
  - All `mem_*` = 0.
  - `a_rvalid` = `b_rvalid` = 0; `a_rdata` = `b_rdata` = 0.
  - `a_gnt` = `b_gnt` = 0.
- Reset mid-operation: the in-flight read is dropped with no `rvalid`. An in-flight write has `mem_wren` forced low immediately.
- Read latency: handshake at edge E0 → ACCESS [E0,E1) → WAIT [E1,E2) → `x_rvalid`=1 and `x_rdata` valid in [E2,E3).
- Throughput:
  - Back-to-back reads: one every 2 cycles.
  - Back-to-back writes: one per cycle.
  - A read may follow a write with no bubble.
- Simultaneous requests: exactly one `gnt` per edge. The loser keeps `req` high and wins the next arbitration point when FIXED_PRIO=0.
- A `req` that drops before `gnt` is legal; nothing is issued for it.

## Test plan
- A reads 0x0010 with `mem_rdata` model = 0xDEADBEEF: `a_gnt` at E0, `mem_cs`=1/`mem_wren`=0/`mem_addr`=0x0010 in [E0,E1), `a_rvalid`=1 with `a_rdata`=0xDEADBEEF in [E2,E3), `b_rvalid` stays 0.
- B writes 0x12345678 to 0x0020 with `be`=4'b0100: `mem_maskwren`=8'h30, `mem_wdata`=0x12345678, `mem_wren`=1 for exactly one cycle, no `rvalid`.
- A and B both hold read requests for 6 arbitration points with FIXED_PRIO=0: grants go A, B, A, B…, and each `rvalid` goes to the requester that issued the read.
- Same stimulus with FIXED_PRIO=1: only A is granted while A holds `req`; B is granted on the first point after `a_req` drops.
- A write to 0x0001 followed immediately by a read of 0x0001 (memory model returns the written 0xCAFEF00D): gnt on consecutive edges, two consecutive ACCESS cycles, `a_rdata`=0xCAFEF00D two cycles later.
- `rst_n` pulled low during WAIT of an A read: `a_rvalid` never pulses, all outputs are 0 while reset is asserted, and after release the first conflict is granted to A.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the 32-bit data SPRAM pair (two 16-bit macros) between
// requester A (CPU data path) and requester B (loader/debug port).
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   a_req/a_we/a_addr/a_wdata/a_be   A command (valid/ready, held until a_gnt)
//   a_gnt                            combinational accept for A
//   a_rvalid/a_rdata                 registered read response for A
//   b_*                              same set for requester B
//   mem_addr/mem_wdata/mem_maskwren  registered SPRAM address, data, nibble mask
//   mem_wren/mem_cs                  registered SPRAM write enable, chip select
//   mem_rdata                        SPRAM DATAOUT, valid the cycle after ACCESS
module dmem_arbiter #(
  parameter int unsigned ADDR_W     = 14,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [31:0]       a_wdata,
  input  logic [3:0]        a_be,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [31:0]       a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_wdata,
  input  logic [3:0]        b_be,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [31:0]       b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [7:0]        mem_maskwren,
  output logic              mem_wren,
  output logic              mem_cs,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned MASK_W = 2 * BE_W;
  localparam logic        OWN_A  = 1'b0;
  localparam logic        OWN_B  = 1'b1;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT} state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic                owner_q, owner_d;
  logic                op_we_q, op_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [MASK_W-1:0]   mem_mask_q, mem_mask_d;
  logic                mem_wren_q, mem_wren_d;
  logic                mem_cs_q, mem_cs_d;
  logic                a_rvalid_q, a_rvalid_d;
  logic                b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;

  logic                ready_c, pick_b_c, a_gnt_c, b_gnt_c, xfer_c;
  logic [BE_W-1:0]     sel_be_c;

  // Arbitration: a lone requester wins; on conflict A wins with fixed
  // priority, otherwise the requester that did not win last time.
  always_comb begin
    ready_c  = (state_q != ST_ACCESS) || op_we_q;
    pick_b_c = b_req && (!a_req || (!FIXED_PRIO && (last_q == OWN_A)));
    a_gnt_c  = ready_c && a_req && !pick_b_c && rst_n;
    b_gnt_c  = ready_c && b_req && pick_b_c && rst_n;
    xfer_c   = a_gnt_c || b_gnt_c;
  end

  // Sequencer next state and registered outputs
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    op_we_d     = op_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_mask_d  = mem_mask_q;
    mem_wren_d  = mem_wren_q;
    mem_cs_d    = mem_cs_q;
    a_rvalid_d  = 1'b0;
    b_rvalid_d  = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    sel_be_c    = b_gnt_c ? b_be : a_be;

    case (state_q)
      ST_ACCESS: begin
        state_d    = op_we_q ? ST_IDLE : ST_WAIT;
        mem_cs_d   = 1'b0;
        mem_wren_d = 1'b0;
      end
      ST_WAIT: begin
        state_d = ST_IDLE;
        if (owner_q == OWN_B) begin
          b_rdata_d  = mem_rdata;
          b_rvalid_d = 1'b1;
        end else begin
          a_rdata_d  = mem_rdata;
          a_rvalid_d = 1'b1;
        end
      end
      default: ;
    endcase

    // A handshake overrides the exit path above (write pipelining, WAIT reuse)
    if (xfer_c) begin
      state_d     = ST_ACCESS;
      owner_d     = b_gnt_c ? OWN_B : OWN_A;
      last_d      = b_gnt_c ? OWN_B : OWN_A;
      op_we_d     = b_gnt_c ? b_we : a_we;
      mem_addr_d  = b_gnt_c ? b_addr : a_addr;
      mem_wdata_d = b_gnt_c ? b_wdata : a_wdata;
      // each byte enable drives the two nibble-mask bits of its byte
      mem_mask_d  = {sel_be_c[3], sel_be_c[3], sel_be_c[2], sel_be_c[2],
                     sel_be_c[1], sel_be_c[1], sel_be_c[0], sel_be_c[0]};
      mem_wren_d  = b_gnt_c ? b_we : a_we;
      mem_cs_d    = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= OWN_B;
      owner_q     <= OWN_A;
      op_we_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_mask_q  <= '0;
      mem_wren_q  <= 1'b0;
      mem_cs_q    <= 1'b0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      op_we_q     <= op_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_mask_q  <= mem_mask_d;
      mem_wren_q  <= mem_wren_d;
      mem_cs_q    <= mem_cs_d;
      a_rvalid_q  <= a_rvalid_d;
      b_rvalid_q  <= b_rvalid_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
    end
  end

  assign a_gnt        = a_gnt_c;
  assign b_gnt        = b_gnt_c;
  assign a_rvalid     = a_rvalid_q;
  assign b_rvalid     = b_rvalid_q;
  assign a_rdata      = a_rdata_q;
  assign b_rdata      = b_rdata_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_maskwren = mem_mask_q;
  assign mem_wren     = mem_wren_q;
  assign mem_cs       = mem_cs_q;

endmodule
